// File: rtl/rng_stat_pkg.sv
// Shared helpers and default pass bands for the generator statistics stages.
package rng_stat_pkg;

   function automatic int clog2(input longint unsigned value);
      int r;
      r = 0;
      for (int i = 0; i < 63; i++) begin
         if ((64'(1) << i) < value) r = i + 1;
      end
      return r;
   endfunction

   localparam int unsigned DEF_WIDTH     = 32;
   localparam int unsigned DEF_BLOCK_LEN = 1024;

   // n = 32*1024 = 32768 bits, alpha = 0.01 two-sided (z = 2.576).
   // Ones: mean n/2 = 16384, sd sqrt(n)/2 = 90.5 -> +/-233.
   // Runs: mean ~(n+1)/2, sd ~sqrt(n-1)/2, band rounded outward.
   localparam int unsigned DEF_ONES_LO = 16151;
   localparam int unsigned DEF_ONES_HI = 16617;
   localparam int unsigned DEF_RUNS_LO = 16151;
   localparam int unsigned DEF_RUNS_HI = 16619;

endpackage

// File: rtl/rng_word_stat.sv
// Per-word popcount and bit-transition count for an LSB-first bit stream.
module rng_word_stat
   import rng_stat_pkg::*;
#(
   parameter int unsigned WIDTH = DEF_WIDTH,
   localparam int unsigned W_W  = clog2(WIDTH + 1)
) (
   input  logic [WIDTH-1:0] sample,
   input  logic             prev_msb,
   input  logic             first,
   output logic [W_W-1:0]   pop,
   output logic [W_W-1:0]   trans
);

   always_comb begin
      pop   = '0;
      trans = '0;
      for (int i = 0; i < WIDTH; i++) begin
         pop = pop + W_W'(sample[i]);
      end
      for (int i = 0; i < WIDTH - 1; i++) begin
         trans = trans + W_W'(sample[i] ^ sample[i+1]);
      end
      // The boundary with the previous word does not exist at a window start.
      if (!first) trans = trans + W_W'(sample[0] ^ prev_msb);
   end

endmodule

// File: rtl/rng_bit_stat.sv
// Windowed monobit and runs statistics over the LCG output stream.
module rng_bit_stat
   import rng_stat_pkg::*;
#(
   parameter int unsigned WIDTH     = DEF_WIDTH,
   parameter int unsigned BLOCK_LEN = DEF_BLOCK_LEN,
   parameter int unsigned ONES_LO   = DEF_ONES_LO,
   parameter int unsigned ONES_HI   = DEF_ONES_HI,
   parameter int unsigned RUNS_LO   = DEF_RUNS_LO,
   parameter int unsigned RUNS_HI   = DEF_RUNS_HI,
   localparam int unsigned CNT_W    = clog2(longint'(WIDTH) * BLOCK_LEN + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] sample_in,
   input  logic             sample_valid,
   output logic [CNT_W-1:0] ones_count,
   output logic [CNT_W-1:0] runs_count,
   output logic             ones_pass,
   output logic             runs_pass,
   output logic             result_valid,
   output logic [15:0]      window_cnt
);

   localparam int unsigned IDX_W = clog2(BLOCK_LEN);
   localparam int unsigned W_W   = clog2(WIDTH + 1);

   logic [IDX_W-1:0] samp_idx;
   logic             prev_msb;
   logic [W_W-1:0]   pop;
   logic [W_W-1:0]   trans;
   logic [W_W-1:0]   s1_pop;
   logic [W_W-1:0]   s1_trans;
   logic             s1_last;
   logic             s1_v;
   logic [CNT_W-1:0] ones_acc;
   logic [CNT_W-1:0] trans_acc;
   logic [CNT_W-1:0] ones_sum;
   logic [CNT_W-1:0] runs_sum;

   rng_word_stat #(.WIDTH(WIDTH)) u_word_stat (
      .sample   (sample_in),
      .prev_msb (prev_msb),
      .first    (samp_idx == '0),
      .pop      (pop),
      .trans    (trans)
   );

   // Stage 1: per-word statistics and window position
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         samp_idx <= '0;
         prev_msb <= 1'b0;
         s1_pop   <= '0;
         s1_trans <= '0;
         s1_last  <= 1'b0;
         s1_v     <= 1'b0;
      end else begin
         s1_v <= sample_valid;
         if (sample_valid) begin
            s1_pop   <= pop;
            s1_trans <= trans;
            s1_last  <= (samp_idx == IDX_W'(BLOCK_LEN - 1));
            prev_msb <= sample_in[WIDTH-1];
            samp_idx <= samp_idx + 1'b1;
         end
      end
   end

   // A run count is one more than the number of transitions in the window.
   assign ones_sum = ones_acc + CNT_W'(s1_pop);
   assign runs_sum = trans_acc + CNT_W'(s1_trans) + CNT_W'(1);

   // Stage 2: accumulate, and publish on the last word of a window
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ones_acc     <= '0;
         trans_acc    <= '0;
         ones_count   <= '0;
         runs_count   <= '0;
         ones_pass    <= 1'b0;
         runs_pass    <= 1'b0;
         result_valid <= 1'b0;
         window_cnt   <= '0;
      end else begin
         result_valid <= 1'b0;
         if (s1_v) begin
            if (s1_last) begin
               ones_count   <= ones_sum;
               runs_count   <= runs_sum;
               ones_pass    <= (32'(ones_sum) >= ONES_LO) && (32'(ones_sum) <= ONES_HI);
               runs_pass    <= (32'(runs_sum) >= RUNS_LO) && (32'(runs_sum) <= RUNS_HI);
               result_valid <= 1'b1;
               window_cnt   <= window_cnt + 16'd1;
               ones_acc     <= '0;
               trans_acc    <= '0;
            end else begin
               ones_acc  <= ones_sum;
               trans_acc <= trans_acc + CNT_W'(s1_trans);
            end
         end
      end
   end

endmodule

// File: tb/tb_rng_bit_stat.sv
// Scoreboard bench for rng_bit_stat with 4-sample windows.
module tb_rng_bit_stat;

   localparam int BL = 4;
   localparam int CW = 8;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [31:0]   sample_in = '0;
   logic          sample_valid = 1'b0;
   logic [CW-1:0] ones_count, runs_count, ones_count_pb, runs_count_pb;
   logic          ones_pass, runs_pass, result_valid;
   logic          ones_pass_pb, runs_pass_pb, result_valid_pb;
   logic [15:0]   window_cnt, window_cnt_pb;

   rng_bit_stat #(.BLOCK_LEN(BL)) dut (
      .clk(clk), .rst(rst), .sample_in(sample_in), .sample_valid(sample_valid),
      .ones_count(ones_count), .runs_count(runs_count), .ones_pass(ones_pass),
      .runs_pass(runs_pass), .result_valid(result_valid), .window_cnt(window_cnt)
   );

   rng_bit_stat #(.BLOCK_LEN(BL), .ONES_LO(64), .ONES_HI(64)) dut_pb (
      .clk(clk), .rst(rst), .sample_in(sample_in), .sample_valid(sample_valid),
      .ones_count(ones_count_pb), .runs_count(runs_count_pb), .ones_pass(ones_pass_pb),
      .runs_pass(runs_pass_pb), .result_valid(result_valid_pb), .window_cnt(window_cnt_pb)
   );

   always #5 clk = ~clk;

   typedef struct {
      int     ones;
      int     runs;
      bit     op;
      bit     rp;
      bit     op_pb;
      int     wcnt;
      longint cyc;
   } exp_t;

   exp_t   sb[$];
   longint cyc = 0;
   int     n_checks = 0;
   int     n_fail = 0;
   int     m_idx = 0, m_ones = 0, m_trans = 0, m_wcnt = 0;
   bit     m_prev = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input longint got, input longint exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   // Bit-serial reference: walks the stream one bit at a time.
   task automatic model_word(input logic [31:0] w);
      exp_t e;
      for (int i = 0; i < 32; i++) begin
         if (!(m_idx == 0 && i == 0) && (w[i] != m_prev)) m_trans++;
         m_prev = w[i];
         m_ones += int'(w[i]);
      end
      m_idx++;
      if (m_idx == BL) begin
         m_wcnt     = (m_wcnt + 1) & 16'hFFFF;
         e.ones     = m_ones;
         e.runs     = m_trans + 1;
         e.op       = (m_ones >= 16151) && (m_ones <= 16617);
         e.rp       = (e.runs >= 16151) && (e.runs <= 16619);
         e.op_pb    = (m_ones == 64);
         e.wcnt     = m_wcnt;
         e.cyc      = cyc + 1;
         sb.push_back(e);
         m_idx   = 0;
         m_ones  = 0;
         m_trans = 0;
      end
   endtask

   task automatic drive(input logic [31:0] w);
      sample_in    = w;
      sample_valid = 1'b1;
      @(posedge clk);
      #1;
      model_word(w);
      sample_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic window(input logic [31:0] w);
      for (int i = 0; i < BL; i++) drive(w);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      idle(2);
      rst = 1'b0;
      m_idx   = 0;
      m_ones  = 0;
      m_trans = 0;
      m_wcnt  = 0;
      m_prev  = 1'b0;
   endtask

   always @(negedge clk) begin
      if (!rst && (result_valid || result_valid_pb)) begin
         if (sb.size() == 0) begin
            chk("spurious_result_valid", 1, 0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("result_valid",    result_valid, 1);
            chk("result_valid_pb", result_valid_pb, 1);
            chk("latency_cycle",   cyc, e.cyc);
            chk("ones_count",      ones_count, e.ones);
            chk("runs_count",      runs_count, e.runs);
            chk("ones_pass",       ones_pass, e.op);
            chk("runs_pass",       runs_pass, e.rp);
            chk("ones_pass_band",  ones_pass_pb, e.op_pb);
            chk("window_cnt",      window_cnt, e.wcnt);
         end
      end else if (!rst && sb.size() != 0 && cyc > sb[0].cyc) begin
         chk("missing_result", 0, 1);
         void'(sb.pop_front());
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout, expected end of stimulus");
      $fatal(1, "watchdog expired");
   end

   initial begin
      #12;
      chk("rst_ones_count",   ones_count, 0);
      chk("rst_runs_count",   runs_count, 0);
      chk("rst_result_valid", result_valid, 0);
      chk("rst_window_cnt",   window_cnt, 0);
      chk("rst_pass",         {ones_pass, runs_pass}, 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      idle(2);

      window(32'h0000_0000);
      idle(3);
      window(32'hFFFF_FFFF);
      idle(3);
      window(32'hAAAA_AAAA);
      idle(3);
      for (int i = 0; i < BL; i++) begin
         drive(32'h0000_0001);
         idle(2);
      end
      idle(3);

      window(32'h0000_0000);
      window(32'hFFFF_FFFF);
      idle(4);

      for (int i = 0; i < 2; i++) drive($urandom);
      do_reset();
      chk("midrst_window_cnt", window_cnt, 0);
      chk("midrst_ones_count", ones_count, 0);
      window(32'h0000_0000);
      idle(4);
      chk("post_rst_window_cnt", window_cnt, 1);

      window(32'hAAAA_AAAA);
      idle(3);
      window(32'h0000_0000);
      idle(3);

      for (int i = 0; i < 3 * BL; i++) begin
         drive($urandom);
         if ($urandom_range(0, 2) == 0) idle(1);
      end
      idle(5);
      chk("scoreboard_empty", sb.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
